// File: rtl/icepic_lib_pkg.sv
// Shared types and constants for the iCEPIC core: program-counter operations,
// sequencer states and the page/literal address-forming helpers.
package icepic_lib_pkg;

  localparam int PC_WIDTH = 12;

  typedef enum logic [2:0] {
    PC_INC    = 3'd0,
    PC_SKIP   = 3'd1,
    PC_GOTO   = 3'd2,
    PC_CALL   = 3'd3,
    PC_RET    = 3'd4,
    PC_PCL_WR = 3'd5
  } pc_op_t;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_FLUSH = 1'b1
  } pc_state_t;

  // GOTO reaches the full 9-bit literal inside the selected page.
  function automatic logic [PC_WIDTH-1:0] pc_goto_target(input logic [2:0] pa,
                                                         input logic [8:0] k);
    return {pa, k};
  endfunction

  // CALL and PCL writes can only land in the lower half of a page.
  function automatic logic [PC_WIDTH-1:0] pc_low_half_target(input logic [2:0] pa,
                                                             input logic [7:0] low);
    return {pa, 1'b0, low};
  endfunction

endpackage

// File: rtl/pc_stack_monitor.sv
// Shadow depth tracker for the hardware return stack; raises a sticky error on
// push-when-full or pop-when-empty. Only built when PC_STACK_CHECK_EN is defined.
module pc_stack_monitor #(
  parameter int STACK_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  output logic err
);

  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic [DW-1:0] depth;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth <= '0;
      err   <= 1'b0;
    end else if (push) begin
      if (depth == FULL) err <= 1'b1;
      else               depth <= depth + DW'(1);
    end else if (pop) begin
      if (depth == '0) err <= 1'b1;
      else             depth <= depth - DW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter and fetch/execute sequencer feeding the 12-bit return stack.
// Define PC_STACK_CHECK_EN to build the shadow stack-depth checker.
module pc_unit
  import icepic_lib_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 12'hFFF,
  parameter int                  STACK_DEPTH  = 2
) (
  input  logic                clk_in,
  input  logic                reset_n_in,
  input  logic                stall_in,
  input  pc_op_t              op_in,
  input  logic [8:0]          k_in,
  input  logic [2:0]          pa_in,
  input  logic [7:0]          pcl_in,
  input  logic [PC_WIDTH-1:0] stack_top_in,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic [7:0]          pcl_out,
  output logic [PC_WIDTH-1:0] stack_data_out,
  output logic                push_out,
  output logic                pop_out,
  output logic                flush_out,
  output logic                stack_err_out
);

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("pc_unit: STACK_DEPTH must be at least 1");
  end

  logic [PC_WIDTH-1:0] pc_q, pc_d, pc_inc;
  pc_state_t           state_q, state_d;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pc_q    <= RESET_VECTOR;
      state_q <= PC_FLUSH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc_inc = pc_q + PC_WIDTH'(1);

  // op_in belongs to the instruction fetched at pc_q-1, so pc_q is the return address.
  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    push_out = 1'b0;
    pop_out  = 1'b0;
    if (!stall_in) begin
      if (state_q == PC_FLUSH) begin
        pc_d    = pc_inc;
        state_d = PC_RUN;
      end else begin
        unique case (op_in)
          PC_SKIP: begin
            pc_d    = pc_inc;
            state_d = PC_FLUSH;
          end
          PC_GOTO: begin
            pc_d    = pc_goto_target(pa_in, k_in);
            state_d = PC_FLUSH;
          end
          PC_CALL: begin
            pc_d     = pc_low_half_target(pa_in, k_in[7:0]);
            push_out = 1'b1;
            state_d  = PC_FLUSH;
          end
          PC_RET: begin
            pc_d    = stack_top_in;
            pop_out = 1'b1;
            state_d = PC_FLUSH;
          end
          PC_PCL_WR: begin
            pc_d    = pc_low_half_target(pa_in, pcl_in);
            state_d = PC_FLUSH;
          end
          default: pc_d = pc_inc;
        endcase
      end
    end
  end

  assign pc_out         = pc_q;
  assign pcl_out        = pc_q[7:0];
  assign stack_data_out = pc_q;
  assign flush_out      = (state_q == PC_FLUSH);

`ifdef PC_STACK_CHECK_EN
  pc_stack_monitor #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack_monitor (
    .clk  (clk_in),
    .rst_n(reset_n_in),
    .push (push_out),
    .pop  (pop_out),
    .err  (stack_err_out)
  );
`else
  assign stack_err_out = 1'b0;
`endif

endmodule
